// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_pkg
// Brief    : Encodings and shared types for the RV32 execute stage.
// Revision : 1.0  initial release
// ============================================================================
package ex_pkg;

    localparam int c_xlen_default = 32;

    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_and  = 4'd2;
    localparam logic [3:0] c_alu_or   = 4'd3;
    localparam logic [3:0] c_alu_xor  = 4'd4;
    localparam logic [3:0] c_alu_sll  = 4'd5;
    localparam logic [3:0] c_alu_srl  = 4'd6;
    localparam logic [3:0] c_alu_sra  = 4'd7;
    localparam logic [3:0] c_alu_slt  = 4'd8;
    localparam logic [3:0] c_alu_sltu = 4'd9;

    localparam logic [1:0] c_md_mul   = 2'd0;
    localparam logic [1:0] c_md_mulhu = 2'd1;
    localparam logic [1:0] c_md_divu  = 2'd2;
    localparam logic [1:0] c_md_remu  = 2'd3;

    // Branch encodings follow the RV32 funct3 field
    localparam logic [2:0] c_br_beq  = 3'd0;
    localparam logic [2:0] c_br_bne  = 3'd1;
    localparam logic [2:0] c_br_blt  = 3'd4;
    localparam logic [2:0] c_br_bge  = 3'd5;
    localparam logic [2:0] c_br_bltu = 3'd6;
    localparam logic [2:0] c_br_bgeu = 3'd7;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    typedef struct packed {
        logic       branch_instruction;
        logic       mem_we;
        logic       mem_re;
        logic       reg_file_write;
        logic [1:0] select_mux_4;
        logic [1:0] select_mux_2;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_if
// Brief    : ID/EX inputs and EX/MEM outputs of the execute stage.
// Revision : 1.0  initial release
// ============================================================================
interface ex_stage_if import ex_pkg::*; #(
    parameter int XLEN = c_xlen_default
) ();
    logic            in_valid;
    logic            flush;
    logic [3:0]      alu_op;
    logic            is_md;
    logic [1:0]      md_op;
    logic [2:0]      branch_func;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] imm;
    logic            branch_instruction_in;
    logic            mem_we_in;
    logic            mem_re_in;
    logic            reg_file_write_in;
    logic [1:0]      select_mux_4_in;
    logic [1:0]      select_mux_2_in;

    logic            busy;
    logic            out_valid;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] reg_out_b;
    logic [XLEN-1:0] add_pc_out;
    logic            branch_out;
    logic            branch_instruction;
    logic            mem_we;
    logic            mem_re;
    logic            reg_file_write;
    logic [1:0]      select_mux_4;
    logic [1:0]      select_mux_2;

    modport slave (
        input  in_valid, flush, alu_op, is_md, md_op, branch_func,
               op_a, op_b, rs2_val, pc_in, imm,
               branch_instruction_in, mem_we_in, mem_re_in, reg_file_write_in,
               select_mux_4_in, select_mux_2_in,
        output busy, out_valid, alu_out, reg_out_b, add_pc_out, branch_out,
               branch_instruction, mem_we, mem_re, reg_file_write,
               select_mux_4, select_mux_2
    );

    modport master (
        output in_valid, flush, alu_op, is_md, md_op, branch_func,
               op_a, op_b, rs2_val, pc_in, imm,
               branch_instruction_in, mem_we_in, mem_re_in, reg_file_write_in,
               select_mux_4_in, select_mux_2_in,
        input  busy, out_valid, alu_out, reg_out_b, add_pc_out, branch_out,
               branch_instruction, mem_we, mem_re, reg_file_write,
               select_mux_4, select_mux_2
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Brief    : One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_iter import ex_pkg::*; #(
    parameter int XLEN     = c_xlen_default,
    parameter int MD_STEPS = XLEN
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_start,
    input  wire logic            i_clear,
    input  wire logic [1:0]      i_op,
    input  wire logic [XLEN-1:0] i_a,
    input  wire logic [XLEN-1:0] i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [XLEN-1:0]      o_result
);
    localparam int              c_cw   = (MD_STEPS > 1) ? $clog2(MD_STEPS) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(MD_STEPS - 1);

    logic [0:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_m;   // multiplicand or divisor
    logic [XLEN-1:0] r_hi;  // product high word or partial remainder
    logic [XLEN-1:0] r_lo;  // multiplier bits or dividend/quotient bits

    logic            w_is_div;
    logic            w_start_div;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;

    assign w_is_div    = (r_op == c_md_divu) || (r_op == c_md_remu);
    assign w_start_div = (i_op == c_md_divu) || (i_op == c_md_remu);

    always_comb begin
        w_sum    = '0;
        w_shift  = '0;
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (w_is_div) begin
            // A zero divisor always "fits", giving all-ones quotient and dividend remainder
            w_shift = {r_hi, r_lo[XLEN-1]};
            if (w_shift >= {1'b0, r_m}) begin
                w_hi_nxt = XLEN'(w_shift - {1'b0, r_m});
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : {XLEN{1'b0}})};
            w_hi_nxt = w_sum[XLEN:1];
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign o_busy   = (r_state == c_st_run);
    assign o_done   = o_busy && (r_cnt == c_last);
    assign o_result = ((r_op == c_md_mul) || (r_op == c_md_divu)) ? w_lo_nxt : w_hi_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_op    <= '0;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (i_clear) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_start) begin
                        r_state <= c_st_run;
                        r_cnt   <= '0;
                        r_op    <= i_op;
                        r_hi    <= '0;
                        r_m     <= w_start_div ? i_b : i_a;
                        r_lo    <= w_start_div ? i_a : i_b;
                    end
                end
                c_st_run: begin
                    r_hi <= w_hi_nxt;
                    r_lo <= w_lo_nxt;
                    if (r_cnt == c_last) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : RV32 execute stage: ALU, branch compare, iterative mul/div, EX/MEM register.
// Revision : 1.0  initial release
// ============================================================================
module ex_stage import ex_pkg::*; #(
    parameter int XLEN     = c_xlen_default,
    parameter int MD_STEPS = XLEN
) (
    input wire logic  clk,
    input wire logic  reset,
    ex_stage_if.slave bus
);
    localparam int c_shw = $clog2(XLEN);

    logic [XLEN-1:0]  w_alu;
    logic             w_cond;
    logic             w_branch;
    logic [XLEN-1:0]  w_add_pc;
    logic [c_shw-1:0] w_shamt;
    ctrl_t            w_ctrl_in;
    logic             w_start;
    logic             w_md_busy;
    logic             w_md_done;
    logic [XLEN-1:0]  w_md_result;

    logic             w_nxt_valid;
    logic [XLEN-1:0]  w_nxt_alu;
    logic [XLEN-1:0]  w_nxt_reg_b;
    logic [XLEN-1:0]  w_nxt_add_pc;
    logic             w_nxt_branch;
    ctrl_t            w_nxt_ctrl;

    logic             r_valid;
    logic [XLEN-1:0]  r_alu_out;
    logic [XLEN-1:0]  r_reg_b;
    logic [XLEN-1:0]  r_add_pc;
    logic             r_branch;
    ctrl_t            r_ctrl;

    // Snapshot of the mul/div instruction's side-band, replayed when the result lands
    logic [XLEN-1:0]  r_h_reg_b;
    logic [XLEN-1:0]  r_h_add_pc;
    logic             r_h_branch;
    ctrl_t            r_h_ctrl;

    assign w_shamt  = bus.op_b[c_shw-1:0];
    assign w_add_pc = bus.pc_in + bus.imm;
    assign w_ctrl_in = '{branch_instruction: bus.branch_instruction_in,
                         mem_we:             bus.mem_we_in,
                         mem_re:             bus.mem_re_in,
                         reg_file_write:     bus.reg_file_write_in,
                         select_mux_4:       bus.select_mux_4_in,
                         select_mux_2:       bus.select_mux_2_in};

    always_comb begin
        w_alu = '0;
        case (bus.alu_op)
            c_alu_add:  w_alu = bus.op_a + bus.op_b;
            c_alu_sub:  w_alu = bus.op_a - bus.op_b;
            c_alu_and:  w_alu = bus.op_a & bus.op_b;
            c_alu_or:   w_alu = bus.op_a | bus.op_b;
            c_alu_xor:  w_alu = bus.op_a ^ bus.op_b;
            c_alu_sll:  w_alu = bus.op_a << w_shamt;
            c_alu_srl:  w_alu = bus.op_a >> w_shamt;
            c_alu_sra:  w_alu = $unsigned($signed(bus.op_a) >>> w_shamt);
            c_alu_slt:  w_alu = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            c_alu_sltu: w_alu = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
            default:    w_alu = '0;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        case (bus.branch_func)
            c_br_beq:  w_cond = (bus.op_a == bus.op_b);
            c_br_bne:  w_cond = (bus.op_a != bus.op_b);
            c_br_blt:  w_cond = ($signed(bus.op_a) <  $signed(bus.op_b));
            c_br_bge:  w_cond = ($signed(bus.op_a) >= $signed(bus.op_b));
            c_br_bltu: w_cond = (bus.op_a <  bus.op_b);
            c_br_bgeu: w_cond = (bus.op_a >= bus.op_b);
            default:   w_cond = 1'b0;
        endcase
    end

    assign w_branch = bus.branch_instruction_in & w_cond;
    assign w_start  = !w_md_busy && bus.in_valid && bus.is_md && !bus.flush;

    muldiv_iter #(
        .XLEN     (XLEN),
        .MD_STEPS (MD_STEPS)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_clear  (bus.flush),
        .i_op     (bus.md_op),
        .i_a      (bus.op_a),
        .i_b      (bus.op_b),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    // Anything other than a finished mul/div or an accepted single-cycle op is a bubble
    always_comb begin
        w_nxt_valid  = 1'b0;
        w_nxt_alu    = '0;
        w_nxt_reg_b  = '0;
        w_nxt_add_pc = '0;
        w_nxt_branch = 1'b0;
        w_nxt_ctrl   = '0;
        if (bus.flush) begin
            w_nxt_valid = 1'b0;
        end else if (w_md_done) begin
            w_nxt_valid  = 1'b1;
            w_nxt_alu    = w_md_result;
            w_nxt_reg_b  = r_h_reg_b;
            w_nxt_add_pc = r_h_add_pc;
            w_nxt_branch = r_h_branch;
            w_nxt_ctrl   = r_h_ctrl;
        end else if (!w_md_busy && bus.in_valid && !bus.is_md) begin
            w_nxt_valid  = 1'b1;
            w_nxt_alu    = w_alu;
            w_nxt_reg_b  = bus.rs2_val;
            w_nxt_add_pc = w_add_pc;
            w_nxt_branch = w_branch;
            w_nxt_ctrl   = w_ctrl_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_alu_out <= '0;
            r_reg_b   <= '0;
            r_add_pc  <= '0;
            r_branch  <= 1'b0;
            r_ctrl    <= '0;
        end else begin
            r_valid   <= w_nxt_valid;
            r_alu_out <= w_nxt_alu;
            r_reg_b   <= w_nxt_reg_b;
            r_add_pc  <= w_nxt_add_pc;
            r_branch  <= w_nxt_branch;
            r_ctrl    <= w_nxt_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_reg_b  <= '0;
            r_h_add_pc <= '0;
            r_h_branch <= 1'b0;
            r_h_ctrl   <= '0;
        end else if (w_start) begin
            r_h_reg_b  <= bus.rs2_val;
            r_h_add_pc <= w_add_pc;
            r_h_branch <= w_branch;
            r_h_ctrl   <= w_ctrl_in;
        end
    end

    assign bus.busy               = w_md_busy;
    assign bus.out_valid          = r_valid;
    assign bus.alu_out            = r_alu_out;
    assign bus.reg_out_b          = r_reg_b;
    assign bus.add_pc_out         = r_add_pc;
    assign bus.branch_out         = r_branch;
    assign bus.branch_instruction = r_ctrl.branch_instruction;
    assign bus.mem_we             = r_ctrl.mem_we;
    assign bus.mem_re             = r_ctrl.mem_re;
    assign bus.reg_file_write     = r_ctrl.reg_file_write;
    assign bus.select_mux_4       = r_ctrl.select_mux_4;
    assign bus.select_mux_2       = r_ctrl.select_mux_2;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Randomised scoreboard bench for ex_stage against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage;
    import ex_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if #(.XLEN(32)) bus ();

    ex_stage #(.XLEN(32), .MD_STEPS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] reg_b;
        logic [31:0] add_pc;
        logic        br;
        logic        bi;
        logic        we;
        logic        re;
        logic        rfw;
        logic [1:0]  s4;
        logic [1:0]  s2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [2:0] bf_tab [6] = '{c_br_beq, c_br_bne, c_br_blt, c_br_bge, c_br_bltu, c_br_bgeu};

    function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned sh = b & 32'd31;
        int          sa = a;
        int          sb = b;
        case (op)
            c_alu_add:  return a + b;
            c_alu_sub:  return a - b;
            c_alu_and:  return a & b;
            c_alu_or:   return a | b;
            c_alu_xor:  return a ^ b;
            c_alu_sll:  return a << sh;
            c_alu_srl:  return a >> sh;
            c_alu_sra:  return (sa < 0) ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
            c_alu_slt:  return (sa < sb) ? 32'd1 : 32'd0;
            c_alu_sltu: return (a < b) ? 32'd1 : 32'd0;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic logic br_ref(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic bi);
        int sa = a;
        int sb = b;
        if (!bi) return 1'b0;
        case (f)
            c_br_beq:  return a == b;
            c_br_bne:  return a != b;
            c_br_blt:  return sa < sb;
            c_br_bge:  return sa >= sb;
            c_br_bltu: return a < b;
            c_br_bgeu: return a >= b;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] md_ref(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] p = 64'(a) * 64'(b);
        case (op)
            c_md_mul:   return p[31:0];
            c_md_mulhu: return p[63:32];
            c_md_divu:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:    return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.alu    = bus.is_md ? md_ref(bus.md_op, bus.op_a, bus.op_b)
                             : alu_ref(bus.alu_op, bus.op_a, bus.op_b);
        e.reg_b  = bus.rs2_val;
        e.add_pc = bus.pc_in + bus.imm;
        e.br     = br_ref(bus.branch_func, bus.op_a, bus.op_b, bus.branch_instruction_in);
        e.bi     = bus.branch_instruction_in;
        e.we     = bus.mem_we_in;
        e.re     = bus.mem_re_in;
        e.rfw    = bus.reg_file_write_in;
        e.s4     = bus.select_mux_4_in;
        e.s2     = bus.select_mux_2_in;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic randomize_fields(input logic allow_flush);
        bus.in_valid              = ($urandom_range(0, 7) != 0);
        bus.flush                 = allow_flush && ($urandom_range(0, 15) == 0);
        bus.is_md                 = 1'b0;
        bus.alu_op                = 4'($urandom_range(0, 9));
        bus.md_op                 = 2'($urandom);
        bus.branch_func           = bf_tab[$urandom_range(0, 5)];
        bus.op_a                  = pick();
        bus.op_b                  = pick();
        bus.rs2_val               = $urandom;
        bus.pc_in                 = $urandom;
        bus.imm                   = pick();
        bus.branch_instruction_in = 1'($urandom);
        bus.mem_we_in             = 1'($urandom);
        bus.mem_re_in             = 1'($urandom);
        bus.reg_file_write_in     = 1'($urandom);
        bus.select_mux_4_in       = 2'($urandom);
        bus.select_mux_2_in       = 2'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_single();
        if (bus.in_valid && !bus.flush && !bus.is_md) exp_q.push_back(expect_now());
        step();
    endtask

    task automatic set_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        randomize_fields(1'b0);
        bus.in_valid              = 1'b1;
        bus.is_md                 = 1'b1;
        bus.md_op                 = op;
        bus.op_a                  = a;
        bus.op_b                  = b;
        bus.branch_instruction_in = 1'b0;
    endtask

    // Upstream noise during the busy window must not disturb the held instruction
    task automatic issue_md();
        exp_q.push_back(expect_now());
        step();
        for (int i = 0; i < 32; i++) begin
            chk("md_busy_high", 128'(bus.busy), 128'd1);
            chk("md_valid_low", 128'(bus.out_valid), 128'd0);
            randomize_fields(1'b0);
            step();
        end
        chk("md_busy_fall", 128'(bus.busy), 128'd0);
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_valid === 1'b1) begin
            exp_t a;
            a = '{alu: bus.alu_out, reg_b: bus.reg_out_b, add_pc: bus.add_pc_out,
                  br: bus.branch_out, bi: bus.branch_instruction, we: bus.mem_we,
                  re: bus.mem_re, rfw: bus.reg_file_write,
                  s4: bus.select_mux_4, s2: bus.select_mux_2};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h required none", a);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL exmem_result: got %0h required %0h", a, e);
                end
            end
        end
    end

    initial begin
        randomize_fields(1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("reset_state",
            {bus.busy, bus.out_valid, bus.alu_out, bus.reg_out_b, bus.add_pc_out,
             bus.branch_out, bus.branch_instruction, bus.mem_we, bus.mem_re,
             bus.reg_file_write, bus.select_mux_4, bus.select_mux_2}, 128'd0);
        repeat (2) step();
        reset = 1'b1;

        randomize_fields(1'b0);
        bus.in_valid = 1'b1;  bus.alu_op = c_alu_add;
        bus.op_a = 32'd5;     bus.op_b = 32'hFFFF_FFFF;  bus.reg_file_write_in = 1'b1;
        issue_single();
        chk("add_result", 128'(bus.alu_out), 128'd4);
        chk("add_rfw", 128'(bus.reg_file_write), 128'd1);
        chk("add_valid", 128'(bus.out_valid), 128'd1);

        randomize_fields(1'b0);
        bus.in_valid = 1'b1;  bus.branch_instruction_in = 1'b1;  bus.branch_func = c_br_blt;
        bus.op_a = 32'hFFFF_FFFE;  bus.op_b = 32'd1;  bus.pc_in = 32'h100;  bus.imm = 32'h20;
        issue_single();
        chk("blt_taken", 128'(bus.branch_out), 128'd1);
        chk("blt_target", 128'(bus.add_pc_out), 128'h120);
        bus.branch_func = c_br_bltu;
        issue_single();
        chk("bltu_not_taken", 128'(bus.branch_out), 128'd0);

        set_md(c_md_mul, 32'd7, 32'd6);                 issue_md();
        chk("mul_result", 128'(bus.alu_out), 128'd42);
        chk("mul_valid", 128'(bus.out_valid), 128'd1);
        set_md(c_md_mulhu, 32'hFFFF_FFFF, 32'd2);       issue_md();
        chk("mulhu_result", 128'(bus.alu_out), 128'd1);
        set_md(c_md_divu, 32'd100, 32'd0);              issue_md();
        chk("divu_by_zero", 128'(bus.alu_out), 128'hFFFF_FFFF);
        set_md(c_md_remu, 32'd100, 32'd0);              issue_md();
        chk("remu_by_zero", 128'(bus.alu_out), 128'd100);
        set_md(c_md_divu, 32'd100, 32'd7);              issue_md();
        chk("divu_result", 128'(bus.alu_out), 128'd14);

        // Flush mid-divide: the partial result must never surface
        set_md(c_md_divu, 32'd1000, 32'd7);
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy", 128'(bus.busy), 128'd0);
        chk("flush_valid", 128'(bus.out_valid), 128'd0);
        randomize_fields(1'b0);
        bus.in_valid = 1'b1;  bus.alu_op = c_alu_add;  bus.op_a = 32'd3;  bus.op_b = 32'd4;
        issue_single();
        chk("post_flush_add", 128'(bus.alu_out), 128'd7);
        chk("post_flush_valid", 128'(bus.out_valid), 128'd1);

        // Asynchronous reset mid-multiply
        set_md(c_md_mul, 32'd123, 32'd456);
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        #2 reset = 1'b0;
        #1;
        chk("reset_mid_run",
            {bus.busy, bus.out_valid, bus.alu_out, bus.reg_out_b, bus.add_pc_out,
             bus.branch_out, bus.branch_instruction, bus.mem_we, bus.mem_re,
             bus.reg_file_write, bus.select_mux_4, bus.select_mux_2}, 128'd0);
        step();
        reset = 1'b1;
        randomize_fields(1'b0);
        bus.in_valid = 1'b1;  bus.alu_op = c_alu_add;  bus.op_a = 32'd10;  bus.op_b = 32'd20;
        issue_single();
        chk("post_reset_add", 128'(bus.alu_out), 128'd30);
        chk("post_reset_busy", 128'(bus.busy), 128'd0);

        for (int n = 0; n < 300; n++) begin
            randomize_fields(1'b1);
            if (bus.in_valid && !bus.flush && $urandom_range(0, 19) == 0) begin
                bus.is_md                 = 1'b1;
                bus.branch_instruction_in = 1'b0;
                issue_md();
            end else begin
                issue_single();
            end
        end

        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (3) step();
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline; sits directly upstream of the MEM stage and owns the EX/MEM pipeline register.
- Performs single-cycle ALU ops, branch-condition evaluation and branch-target add.
- Performs iterative unsigned multiply/divide (MUL, MULHU, DIVU, REMU), stalling the front-end while busy.
- All outputs are registered and drive the MEM stage inputs of the same names.

Parameters:
XLEN, 32, datapath width
MD_STEPS, 32, iterations per mul/div operation (equals XLEN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
in_valid  in  1  instruction present at EX inputs
flush  in  1  synchronous kill of current EX instruction
alu_op  in  4  ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU
is_md  in  1  instruction is mul/div
md_op  in  2  MUL,MULHU,DIVU,REMU
branch_func  in  3  BEQ,BNE,BLT,BGE,BLTU,BGEU
op_a  in  32  rs1 value
op_b  in  32  second ALU operand (rs2 or imm, selected upstream)
rs2_val  in  32  store data
pc_in  in  32  instruction PC
imm  in  32  branch/jump offset
branch_instruction_in, mem_we_in, mem_re_in, reg_file_write_in  in  1 each  control bits
select_mux_4_in, select_mux_2_in  in  2 each  downstream mux selects
busy  out  1  mul/div in progress; upstream must hold inputs
out_valid  out  1  EX/MEM register holds a real instruction
alu_out  out  32  ALU or mul/div result
reg_out_b  out  32  registered rs2_val
add_pc_out  out  32  pc_in + imm (mod 2^32)
branch_out  out  1  branch condition true
branch_instruction, mem_we, mem_re, reg_file_write  out  1 each  registered controls
select_mux_4, select_mux_2  out  2 each  registered selects

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM IDLE, step counter 0, busy 0.
- Single-cycle op (in_valid=1, is_md=0, FSM IDLE): all outputs load on the next edge; latency 1.
- Arithmetic is mod 2^32; shifts use op_b[4:0]; SLT is signed; SLTU is unsigned.
- Branch conditions: BLT/BGE are signed; BLTU/BGEU are unsigned.
- branch_out is 0 when branch_instruction_in=0.
- in_valid=0: a bubble is loaded (out_valid and all control bits 0, data registers don't-care but deterministic).
- FSM states: IDLE, RUN.
- IDLE->RUN: on an edge with in_valid=1, is_md=1, flush=0.
  - Operands are latched; counter is cleared.
  - A bubble is loaded into EX/MEM.
  - busy=1 from that edge.
- In RUN: each edge performs one step.
  - MUL/MULHU: shift-add, 64-bit product.
  - DIVU/REMU: restoring divide.
  - Counter increments each step; a bubble is loaded each cycle.
  - Upstream inputs are ignored while in RUN.
- RUN->IDLE: on the edge where counter==MD_STEPS-1.
  - The final step completes and EX/MEM loads the result: MUL=low word, MULHU=high word, DIVU=quotient, REMU=remainder.
  - Controls are loaded from the held inputs; out_valid=1.
  - busy falls on the same edge.
  - Total: result visible MD_STEPS+1 edges after acceptance; busy high for exactly MD_STEPS cycles.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend, with no early exit (same latency).
- flush=1 on an edge: bubble loaded; FSM forced to IDLE, counter cleared, busy 0. flush has priority over in_valid.
- Reset mid-RUN: immediate IDLE, outputs 0. No partial result is ever emitted.

Decomposition:
- Package ex_pkg holds:
  - alu_op, md_op and branch_func encodings
  - FSM state enum
  - XLEN default
- Sub-module muldiv_iter contains the FSM, counter, accumulator/remainder registers and the busy/done handshake (start, op, a, b -> busy, done, result).
- ex_stage instantiates muldiv_iter and holds the ALU, comparator and EX/MEM register.

Test Plan:
- ADD op_a=5, op_b=0xFFFFFFFF, reg_file_write_in=1 -> after 1 edge: alu_out=4, reg_file_write=1, out_valid=1.
- BLT op_a=0xFFFFFFFE, op_b=1, pc_in=0x100, imm=0x20 -> branch_out=1, add_pc_out=0x120. Same operands with BLTU -> branch_out=0.
- MUL 7*6 -> busy high 32 cycles, out_valid=0 during busy, alu_out=42 with out_valid=1 on edge 33. MULHU 0xFFFFFFFF*2 -> alu_out=1.
- DIVU 100/0 -> alu_out=0xFFFFFFFF after 33 edges. REMU 100/0 -> 100. DIVU 100/7 -> 14.
- flush at step 10 of a DIVU -> busy 0 next edge, out_valid=0. Next ADD executes with latency 1.
- reset=0 at step 5 of a MUL -> all outputs 0 immediately. After release, an ADD completes normally.
